// File: rtl/relu_act_stream.sv
// Streaming activation unit: ReLU / leaky / clamp / bypass over LANES pixels per beat.
// Two-stage pipeline with per-frame negative-pixel counting.
module relu_act_stream #(
  parameter int          DATA_WIDTH = 32,
  parameter int          R          = 3,
  parameter int          C          = 3,
  parameter int          LANES      = 3,
  parameter int          LEAK_SHIFT = 3,
  parameter logic [31:0] CLAMP_MAX  = 32'h0006_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH*LANES-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH*LANES-1:0]   out_data,
  output logic                          out_last,
  output logic [$clog2(R*C+1)-1:0]      neg_count
);

  localparam int DW    = DATA_WIDTH;
  localparam int PW    = DATA_WIDTH * LANES;
  localparam int BEATS = R * C / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int NW    = $clog2(R * C + 1);
  localparam logic signed [DW-1:0] CMAX = DW'(CLAMP_MAX);

  typedef enum logic [1:0] {
    RELU   = 2'd0,
    LEAKY  = 2'd1,
    CLAMP  = 2'd2,
    BYPASS = 2'd3
  } mode_e;

  logic [CW-1:0] cnt_q, cnt_d;
  mode_e         fmode_q, fmode_d;
  logic          s1_v_q, s1_v_d;
  logic [PW-1:0] s1_data_q, s1_data_d;
  mode_e         s1_mode_q, s1_mode_d;
  logic          s1_last_q, s1_last_d;
  logic          out_v_q, out_v_d;
  logic [PW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [NW-1:0] nacc_q, nacc_d;
  logic [NW-1:0] negc_q, negc_d;

  logic          stall;
  logic          accept;
  logic          last_beat;
  mode_e         beat_mode;
  logic [PW-1:0] act_data;
  logic [NW-1:0] beat_neg;

  assign stall     = out_v_q & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign last_beat = (cnt_q == CW'(BEATS - 1));
  // First beat of a frame takes the live mode; later beats reuse the latched one.
  assign beat_mode = (cnt_q == '0) ? mode_e'(mode) : fmode_q;

  always_comb begin
    logic signed [DW-1:0] px;
    logic signed [DW-1:0] py;
    act_data = '0;
    beat_neg = '0;
    px       = '0;
    py       = '0;
    for (int i = 0; i < LANES; i++) begin
      px = s1_data_q[i*DW +: DW];
      py = px;
      case (s1_mode_q)
        RELU:    if (px[DW-1]) py = '0;
        LEAKY:   if (px[DW-1]) py = px >>> LEAK_SHIFT;
        CLAMP: begin
          if (px[DW-1])       py = '0;
          else if (px > CMAX) py = CMAX;
        end
        default: py = px;
      endcase
      act_data[i*DW +: DW] = py;
      beat_neg = beat_neg + NW'(px[DW-1]);
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    fmode_d    = fmode_q;
    s1_v_d     = s1_v_q;
    s1_data_d  = s1_data_q;
    s1_mode_d  = s1_mode_q;
    s1_last_d  = s1_last_q;
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    nacc_d     = nacc_q;
    negc_d     = negc_q;
    if (accept) begin
      cnt_d = last_beat ? '0 : cnt_q + 1'b1;
      if (cnt_q == '0) fmode_d = mode_e'(mode);
    end
    if (!stall) begin
      s1_v_d = accept;
      if (accept) begin
        s1_data_d = in_data;
        s1_mode_d = beat_mode;
        s1_last_d = last_beat;
      end
      out_v_d = s1_v_q;
      if (s1_v_q) begin
        out_data_d = act_data;
        out_last_d = s1_last_q;
        if (s1_last_q) begin
          negc_d = nacc_q + beat_neg;
          nacc_d = '0;
        end else begin
          nacc_d = nacc_q + beat_neg;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      fmode_q    <= RELU;
      s1_v_q     <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= RELU;
      s1_last_q  <= 1'b0;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      nacc_q     <= '0;
      negc_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      fmode_q    <= fmode_d;
      s1_v_q     <= s1_v_d;
      s1_data_q  <= s1_data_d;
      s1_mode_q  <= s1_mode_d;
      s1_last_q  <= s1_last_d;
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      nacc_q     <= nacc_d;
      negc_q     <= negc_d;
    end
  end

  assign out_valid = out_v_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign neg_count = negc_q;

endmodule

// File: tb/tb_relu_act_stream.sv
// Randomised and directed bench for relu_act_stream against a frame-level model.
// DATA_WIDTH=16, 3x3 map, 3 lanes, LEAK_SHIFT=3, CLAMP_MAX=100.
module tb_relu_act_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] out_data;
  logic        out_last;
  logic [3:0]  neg_count;

  relu_act_stream #(
    .DATA_WIDTH(16), .R(3), .C(3), .LANES(3),
    .LEAK_SHIFT(3), .CLAMP_MAX(32'd100)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .neg_count(neg_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] data;
    logic        last;
    int          neg;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mb = 0;
  int fneg = 0;
  logic [1:0] fm = 2'd0;
  beat_t mbeat, obeat;
  int nb;
  logic [15:0] lx;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model: activation by plain integer arithmetic.
  function automatic logic [15:0] act(input logic [15:0] x, input logic [1:0] m);
    int v, r;
    v = int'($signed(x));
    case (m)
      2'd0:    r = (v < 0) ? 0 : v;
      2'd1:    r = (v < 0) ? (v - 7) / 8 : v;
      2'd2:    r = (v < 0) ? 0 : ((v > 100) ? 100 : v);
      default: r = v;
    endcase
    return r[15:0];
  endfunction

  function automatic logic [47:0] pk(input int a, input int b, input int c);
    logic [15:0] x, y, z;
    x = a[15:0];
    y = b[15:0];
    z = c[15:0];
    return {z, y, x};
  endfunction

  function automatic logic [15:0] rlane();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'($urandom_range(0, 240)) - 16'd120;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      nb = 0;
      if (mb == 0) fm = mode;
      for (int i = 0; i < 3; i++) begin
        lx = in_data[16*i +: 16];
        if ($signed(lx) < 0) nb++;
        mbeat.data[16*i +: 16] = act(lx, fm);
      end
      fneg += nb;
      mbeat.last = (mb == 2);
      mbeat.neg  = mbeat.last ? fneg : -1;
      mbeat.cyc  = cyc;
      if (mbeat.last) fneg = 0;
      mb = (mb + 1) % 3;
      exp_q.push_back(mbeat);
    end
    if (!rst && out_valid && out_ready) begin
      obeat.data = out_data;
      obeat.last = out_last;
      obeat.neg  = int'(neg_count);
      obeat.cyc  = cyc;
      obs_q.push_back(obeat);
    end
  end

  task automatic send(input logic [47:0] d, input logic [1:0] m);
    bit ok;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while ((out_valid || exp_q.size() != obs_q.size()) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 48'h0 ||
        neg_count !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v=%b l=%b d=%h n=%0d r=%b want 0/0/0/0/1",
               out_valid, out_last, out_data, neg_count, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got r=%b v=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_relu();
    beat_t e, o;
    logic [47:0] want[3];
    int k = 0;
    want[0] = pk(0, 0, 7);
    want[1] = pk(0, 0, 200);
    want[2] = pk(3, 4, 0);
    out_ready = 1'b1;
    send(pk(-5, 0, 7), 2'd0);
    send(pk(-1, -32768, 200), 2'd0);
    send(pk(3, 4, -9), 2'd0);
    drain();
    checks++;
    if (obs_q.size() !== 3) begin
      errors++;
      $display("FAIL relu_count got %0d want 3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.data !== want[k] || o.data !== e.data || o.last !== (k == 2) ||
          o.cyc - e.cyc !== 2 || (k == 2 && o.neg !== 4)) begin
        errors++;
        $display("FAIL relu_beat%0d got %h/%b/lat%0d/n%0d want %h/%b/lat2/n4",
                 k, o.data, o.last, o.cyc - e.cyc, o.neg, want[k], k == 2);
      end
      k++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_leaky_clamp();
    beat_t e, o;
    logic [47:0] din[9];
    logic [47:0] dw[9];
    logic [1:0]  fmode[3];
    int k = 0;
    fmode[0] = 2'd1;
    fmode[1] = 2'd2;
    fmode[2] = 2'd3;
    din[0] = pk(-16, -1, 8);         dw[0] = pk(-2, -1, 8);
    din[1] = pk(-32768, 32767, -9);  dw[1] = pk(-4096, 32767, -2);
    din[2] = pk(0, -8, 5);           dw[2] = pk(0, -1, 5);
    din[3] = pk(150, 100, -3);       dw[3] = pk(100, 100, 0);
    din[4] = pk(101, 99, 0);         dw[4] = pk(100, 99, 0);
    din[5] = pk(-32768, 32767, 1);   dw[5] = pk(0, 100, 1);
    din[6] = pk(-5, 6, -32768);      dw[6] = pk(-5, 6, -32768);
    din[7] = pk(0, -1, 1);           dw[7] = pk(0, -1, 1);
    din[8] = pk(300, -300, 7);       dw[8] = pk(300, -300, 7);
    for (int i = 0; i < 9; i++) send(din[i], fmode[i/3]);
    drain();
    checks++;
    if (obs_q.size() !== 9) begin
      errors++;
      $display("FAIL modes_count got %0d want 9", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.data !== dw[k] || o.data !== e.data || o.last !== e.last ||
          (e.last && o.neg !== e.neg)) begin
        errors++;
        $display("FAIL modes_beat%0d got %h/%b/n%0d want %h/%b/n%0d",
                 k, o.data, o.last, o.neg, dw[k], e.last, e.neg);
      end
      k++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_mode_change();
    beat_t e, o;
    logic [1:0] ms[6];
    logic [47:0] w;
    int k = 0;
    ms[0] = 2'd0; ms[1] = 2'd2; ms[2] = 2'd2;
    ms[3] = 2'd2; ms[4] = 2'd0; ms[5] = 2'd1;
    for (int i = 0; i < 6; i++) send(pk(150, -4, 50), ms[i]);
    drain();
    checks++;
    if (obs_q.size() !== 6) begin
      errors++;
      $display("FAIL modechg_count got %0d want 6", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      w = (k < 3) ? pk(150, 0, 50) : pk(100, 0, 50);
      checks++;
      if (o.data !== w || o.data !== e.data || o.last !== e.last ||
          (e.last && o.neg !== 3)) begin
        errors++;
        $display("FAIL modechg_beat%0d got %h/%b/n%0d want %h/%b/n3",
                 k, o.data, o.last, o.neg, w, e.last);
      end
      k++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_stall();
    beat_t e, o;
    logic [47:0] held;
    int n = 0;
    out_ready = 1'b0;
    fork
      begin
        send(pk(11, -12, 13), 2'd0);
        send(pk(-21, 22, 23), 2'd0);
        send(pk(31, 32, -33), 2'd0);
      end
      begin
        do begin
          @(negedge clk);
          n++;
        end while (!out_valid && n < 20);
        held = out_data;
        for (int i = 0; i < 4; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held ||
              held !== pk(11, 0, 13)) begin
            errors++;
            $display("FAIL stall_hold%0d got r=%b v=%b d=%h want 0/1/%h",
                     i, in_ready, out_valid, out_data, pk(11, 0, 13));
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (obs_q.size() !== 3 || exp_q.size() !== 3) begin
      errors++;
      $display("FAIL stall_count got %0d want 3", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || (e.last && o.neg !== e.neg)) begin
        errors++;
        $display("FAIL stall_beat got %h/%b/n%0d want %h/%b/n%0d",
                 o.data, o.last, o.neg, e.data, e.last, e.neg);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    beat_t e, o;
    bit done = 1'b0;
    int nbeats = 0;
    fork
      begin
        for (int f = 0; f < 300; f++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          send({rlane(), rlane(), rlane()}, 2'($urandom_range(0, 3)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (obs_q.size() !== 300 || exp_q.size() !== 300) begin
      errors++;
      $display("FAIL rand_count got %0d want 300", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || (e.last && o.neg !== e.neg)) begin
        errors++;
        $display("FAIL rand_beat%0d got %h/%b/n%0d want %h/%b/n%0d",
                 nbeats, o.data, o.last, o.neg, e.data, e.last, e.neg);
      end
      nbeats++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_mid_reset();
    beat_t e, o;
    out_ready = 1'b1;
    send(pk(-1, -1, -1), 2'd0);
    send(pk(-1, -1, -1), 2'd0);
    send(pk(-1, -1, -1), 2'd0);
    drain();
    exp_q.delete();
    obs_q.delete();
    send(pk(7, -1, 9), 2'd0);
    send(pk(5, 5, -5), 2'd0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 48'h0 || out_last !== 1'b0 ||
        neg_count !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async got v=%b d=%h l=%b n=%0d r=%b want 0/0/0/0/1",
               out_valid, out_data, out_last, neg_count, in_ready);
    end
    exp_q.delete();
    obs_q.delete();
    mb   = 0;
    fneg = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    send(pk(-1, -2, 3), 2'd2);
    send(pk(4, -5, 6), 2'd0);
    send(pk(7, 8, 200), 2'd0);
    drain();
    checks++;
    if (obs_q.size() !== 3 || neg_count !== 4'd3) begin
      errors++;
      $display("FAIL midrst_frame got %0d beats n=%0d want 3 beats n=3",
               obs_q.size(), neg_count);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || (e.last && o.neg !== e.neg)) begin
        errors++;
        $display("FAIL midrst_beat got %h/%b/n%0d want %h/%b/n%0d",
                 o.data, o.last, o.neg, e.data, e.last, e.neg);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_relu();
    test_leaky_clamp();
    test_mode_change();
    test_stall();
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_act_stream.md
RELU_ACT_STREAM -- requirements
Module: relu_act_stream

Interface
REQ-001 The block SHALL expose these parameters:
- DATA_WIDTH, 32, signed two's-complement pixel width.
- R, 3, feature-map rows.
- C, 3, feature-map columns.
- LANES, 3, pixels per beat; R*C SHALL be an integer multiple of LANES.
- LEAK_SHIFT, 3, arithmetic right-shift applied to negatives in leaky mode.
- CLAMP_MAX, 32'h0006_0000, upper saturation value in clamp mode, truncated to DATA_WIDTH.

REQ-002 The block SHALL expose these ports, with clock and reset first:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  activation select: 0 = ReLU, 1 = leaky ReLU, 2 = clamp (ReLU6-style), 3 = bypass.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the input beat.
- in_data  in  DATA_WIDTH*LANES  input pixels; lane i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  DATA_WIDTH*LANES  activated pixels, same lane packing as in_data.
- out_last  out  1  marks the final beat of a frame.
- neg_count  out  $clog2(R*C+1)  number of negative input pixels in the most recently completed frame.

Function
REQ-003 A frame SHALL be BEATS = R*C/LANES accepted beats. An input beat is accepted when in_valid and in_ready are both high.
REQ-004 The block SHALL keep an input beat counter from 0 to BEATS-1, advanced on each accepted beat. It SHALL wrap to 0 after the beat accepted at BEATS-1.
REQ-005 The mode value SHALL be sampled on the beat accepted at counter 0 and applied to every beat of that frame. Changes to mode mid-frame SHALL be ignored until the next frame.
REQ-006 Each lane SHALL be processed independently for input pixel x, as signed arithmetic:
- ReLU: x<0 gives 0, otherwise x.
- Leaky: x<0 gives x>>>LEAK_SHIFT, otherwise x.
- Clamp: x<0 gives 0; x>CLAMP_MAX gives CLAMP_MAX; otherwise x.
- Bypass: x unchanged.
REQ-007 x = 0 SHALL be treated as non-negative. The most-negative value SHALL shift arithmetically without overflow.
REQ-008 The datapath SHALL be a 2-stage pipeline:
- Stage 1 registers the accepted beat, its frame mode and its last flag.
- Stage 2 registers the activated result.
- Latency SHALL be exactly 2 clock cycles from acceptance to out_valid when unstalled.
- Sustained throughput SHALL be 1 beat per cycle.
REQ-009 Backpressure:
- The pipeline SHALL stall whenever out_valid=1 and out_ready=0.
- in_ready SHALL be the negation of that stall condition.
- While stalled, out_data, out_valid and out_last SHALL hold stable, and no internal state SHALL advance.
REQ-010 The pipeline SHALL fill bubbles: a stage whose valid is low SHALL be overwritten regardless of downstream state, without creating duplicate or lost beats.
REQ-011 out_last SHALL be high exactly on the output beat that came from input counter BEATS-1.
REQ-012 Negative-pixel counting:
- A per-frame accumulator SHALL count lanes with x<0, independent of mode.
- neg_count SHALL take the frame total in the same cycle out_last first goes high.
- neg_count SHALL hold that value until the next frame's last beat.
- The accumulator SHALL clear for the following frame.
REQ-013 When out_valid=0, out_data and out_last SHALL retain their previous values; they carry no meaning while invalid.

Reset
REQ-014 When rst is asserted, the following SHALL immediately and asynchronously become 0:
- out_valid, out_last, out_data and neg_count;
- the beat counter, the negative-count accumulator and all stage valids.
REQ-015 Reset asserted mid-frame SHALL discard the partial frame. The first beat accepted after deassertion SHALL be counter 0 and SHALL sample mode.
REQ-016 in_ready SHALL be 1 during and immediately after reset.

Verification
All scenarios use DATA_WIDTH=16, R=C=3, LANES=3 (BEATS=3), LEAK_SHIFT=3, CLAMP_MAX=100.
REQ-017 ReLU mode, out_ready=1, frame {-5,0,7},{-1,-32768,200},{3,4,-9}:
- outputs {0,0,7},{0,0,200},{3,4,0}, each 2 cycles after input;
- out_last on beat 3 only;
- neg_count=4.
REQ-018 Leaky mode, beat {-16,-1,8} gives {-2,-1,8}; clamp mode, beat {150,100,-3} gives {100,100,0}.
REQ-019 mode changed from 0 to 2 during beat 2 of a frame: that frame stays ReLU; the next frame applies clamp from its beat 1.
REQ-020 Stall: hold out_ready=0 for 4 cycles with continuous in_valid:
- in_ready drops once out_valid=1;
- out_data stays constant;
- after release, all 3 beats emerge in order with no loss or duplication.
REQ-021 Random in_valid/out_ready toggling over 100 frames: output stream matches a reference model beat-for-beat, and neg_count matches per frame.
REQ-022 Reset after beat 2 of a frame, then a new full frame: outputs go 0 asynchronously; the new frame produces exactly 3 beats, out_last on its third, and neg_count reflects only the new frame.
